// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, encodings and fetch action type
package cpu_pkg;

  localparam int          ADDR_W    = 16;
  localparam int          INSTR_W   = 16;
  localparam int          CNT_W     = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  // What the fetch stage does on a given edge, highest priority first.
  typedef enum logic [1:0] {
    FETCH_REDIRECT = 2'd0,
    FETCH_HOLD     = 2'd1,
    FETCH_BUBBLE   = 2'd2,
    FETCH_NORMAL   = 2'd3
  } fetch_action_e;

  function automatic fetch_action_e fetch_action(input logic branch_slot,
                                                 input logic load_slot,
                                                 input logic struct_stall,
                                                 input logic imem_ready);
    if (branch_slot)                      return FETCH_REDIRECT;
    else if (load_slot)                   return FETCH_HOLD;
    else if (struct_stall || !imem_ready) return FETCH_BUBBLE;
    else                                  return FETCH_NORMAL;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory fetch bus
interface fetch_stage_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ready;

  // Fetch stage drives the address; memory returns the word and its ready flag.
  modport master (output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline register with hold and flush
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = cpu_pkg::ADDR_W,
  parameter int          INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc_next,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_next,
  output logic               ifid_valid
);

  // Flush beats hold: a bubble replaces whatever was held; pc_next is left as-is on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr   <= INSTR_W'(NOP_INSTR);
      ifid_pc_next <= '0;
      ifid_valid   <= 1'b0;
    end else if (flush) begin
      ifid_instr   <= INSTR_W'(NOP_INSTR);
      ifid_valid   <= 1'b0;
    end else if (!hold) begin
      ifid_instr   <= d_instr;
      ifid_pc_next <= d_pc_next;
      ifid_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, next-PC mux, bubble counter, IF/ID register
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = cpu_pkg::ADDR_W,
  parameter int          INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter logic [15:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int          CNT_W     = cpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_slot,
  input  logic               branch_slot,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               struct_stall,
  fetch_stage_if.master      imem,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_next,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   bubble_cnt
);

  fetch_action_e     action;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_d;
  logic              bubble;

  assign imem.imem_addr = pc;
  assign pc_plus1       = pc + ADDR_W'(1);

  // Decode the per-edge action and select the next PC; branch_target is only
  // looked at on a redirect so an undriven target cannot leak into the PC.
  always_comb begin
    action = fetch_action(branch_slot, load_slot, struct_stall, imem.imem_ready);
    pc_d   = pc;
    bubble = 1'b0;
    case (action)
      FETCH_REDIRECT: begin
        pc_d   = branch_target;
        bubble = 1'b1;
      end
      FETCH_HOLD:   pc_d = pc;
      FETCH_BUBBLE: begin
        pc_d   = pc;
        bubble = 1'b1;
      end
      FETCH_NORMAL: pc_d = pc_plus1;
      default:      pc_d = pc;
    endcase
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc <= ADDR_W'(RESET_PC);
    else     pc <= pc_d;
  end

  // Saturating count of injected bubbles.
  always_ff @(posedge clk) begin
    if (rst)                             bubble_cnt <= '0;
    else if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

  ifid_reg #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk          (clk),
    .rst          (rst),
    .hold         (action == FETCH_HOLD),
    .flush        (bubble),
    .d_instr      (imem.imem_rdata),
    .d_pc_next    (pc_plus1),
    .ifid_instr   (ifid_instr),
    .ifid_pc_next (ifid_pc_next),
    .ifid_valid   (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc_next;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_slot = 1'b0;
  logic        branch_slot = 1'b0;
  logic [15:0] branch_target = 'x;
  logic        struct_stall = 1'b0;
  logic        tb_ready = 1'b0;
  logic [15:0] pc, ifid_instr, ifid_pc_next, bubble_cnt;
  logic        ifid_valid;

  int compared = 0;
  int failed   = 0;

  exp_t exp_q[$];
  exp_t m;
  exp_t e;
  exp_t got;

  fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  assign bus.imem_ready = tb_ready;
  assign bus.imem_rdata = tb_ready ? (bus.imem_addr ^ 16'hA5A5) : 16'hDEAD;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .load_slot     (load_slot),
    .branch_slot   (branch_slot),
    .branch_target (branch_target),
    .struct_stall  (struct_stall),
    .imem          (bus.master),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_next  (ifid_pc_next),
    .ifid_valid    (ifid_valid),
    .bubble_cnt    (bubble_cnt)
  );

  always #5 clk = ~clk;

  assign got = '{pc: pc, instr: ifid_instr, pc_next: ifid_pc_next, valid: ifid_valid, cnt: bubble_cnt};

  // Drive one cycle of stimulus, push the reference result, clock, sample 1 time unit later.
  task automatic tick(input logic r, input logic b, input logic l, input logic s,
                      input logic rdy, input logic [15:0] tgt);
    rst = r; branch_slot = b; load_slot = l; struct_stall = s; tb_ready = rdy;
    branch_target = b ? tgt : 16'hxxxx;
    if (r) begin
      m = '{pc: 16'h0000, instr: 16'h0800, pc_next: 16'h0000, valid: 1'b0, cnt: 16'h0000};
    end else if (b) begin
      m.pc = tgt; m.instr = 16'h0800; m.valid = 1'b0;
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    end else if (l) begin
      m = m;
    end else if (s || !rdy) begin
      m.instr = 16'h0800; m.valid = 1'b0;
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    end else begin
      m.instr = m.pc ^ 16'hA5A5; m.pc_next = m.pc + 16'd1; m.valid = 1'b1; m.pc = m.pc + 16'd1;
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0);
    void'(exp_q.pop_front());
    tick(1, 0, 0, 1, 1, 0);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || got !== exp_t'({16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0000})) begin
      failed++; $display("FAIL reset got=%h want=%h", got, e);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] prev;
    for (int i = 0; i < 5; i++) begin
      prev = pc;
      tick(0, 0, 0, 0, 1, 0);
      e = exp_q.pop_front();
      compared++;
      if (got !== e || ifid_instr !== (prev ^ 16'hA5A5) || pc !== 16'(i + 1)) begin
        failed++; $display("FAIL seq%0d got=%h want=%h", i, got, e);
      end
    end
  endtask

  task automatic test_load_hold();
    exp_t snap;
    snap = got;
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 1, 0, 1, 0);
      e = exp_q.pop_front();
      compared++;
      if (got !== e || got !== snap || pc !== 16'd5) begin
        failed++; $display("FAIL load_hold%0d got=%h want=%h", i, got, snap);
      end
    end
  endtask

  task automatic test_branch_over_load();
    logic [15:0] c0;
    c0 = bubble_cnt;
    tick(0, 1, 1, 1, 0, 16'h0040);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || pc !== 16'h0040 || ifid_instr !== 16'h0800 || ifid_valid !== 1'b0 ||
        bubble_cnt !== c0 + 16'd1) begin
      failed++; $display("FAIL branch_over_load got=%h want=%h", got, e);
    end
  endtask

  task automatic test_struct_stall();
    tick(0, 1, 0, 0, 1, 16'h0009);
    void'(exp_q.pop_front());
    tick(0, 0, 0, 1, 1, 0);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || pc !== 16'h0009 || ifid_instr !== 16'h0800 || ifid_valid !== 1'b0) begin
      failed++; $display("FAIL struct_stall got=%h want=%h", got, e);
    end
    tick(0, 0, 0, 0, 1, 0);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || ifid_instr !== (16'h0009 ^ 16'hA5A5) || ifid_pc_next !== 16'h000A) begin
      failed++; $display("FAIL after_stall got=%h want=%h", got, e);
    end
  endtask

  task automatic test_imem_wait_redirect();
    logic [15:0] c0;
    c0 = bubble_cnt;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 16'h0100);
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      compared++;
      if (got.cnt !== c0 + 16'd3 && i == 2) begin
        failed++; $display("FAIL wait_cnt got=%h want=%h", got.cnt, c0 + 16'd3);
      end else if (i == 2 && got !== e) begin
        failed++; $display("FAIL wait_state got=%h want=%h", got, e);
      end
    end
    tick(0, 0, 0, 0, 1, 0);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || ifid_instr !== (16'h0100 ^ 16'hA5A5) || pc !== 16'h0101) begin
      failed++; $display("FAIL wait_target got=%h want=%h", got, e);
    end
  endtask

  task automatic test_wrap_saturate();
    int guard;
    tick(0, 1, 0, 0, 1, 16'hFFFF);
    void'(exp_q.pop_front());
    tick(0, 0, 0, 0, 1, 0);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || pc !== 16'h0000 || ifid_pc_next !== 16'h0000 ||
        ifid_instr !== (16'hFFFF ^ 16'hA5A5)) begin
      failed++; $display("FAIL pc_wrap got=%h want=%h", got, e);
    end
    guard = 0;
    while (m.cnt != 16'hFFFF && guard < 70000) begin
      tick(0, 0, 0, 1, 1, 0);
      void'(exp_q.pop_front());
      guard++;
    end
    compared++;
    if (bubble_cnt !== 16'hFFFF) begin
      failed++; $display("FAIL cnt_reach_max got=%h want=ffff", bubble_cnt);
    end
    tick(0, 0, 0, 1, 1, 0);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || bubble_cnt !== 16'hFFFF) begin
      failed++; $display("FAIL cnt_saturate got=%h want=ffff", bubble_cnt);
    end
    tick(0, 1, 0, 0, 1, 16'h1234);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || bubble_cnt !== 16'hFFFF || pc !== 16'h1234) begin
      failed++; $display("FAIL cnt_saturate_branch got=%h want=%h", got, e);
    end
    tick(1, 0, 0, 1, 1, 0);
    e = exp_q.pop_front();
    compared++;
    if (got !== e || got !== exp_t'({16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0000})) begin
      failed++; $display("FAIL reset_mid_stall got=%h want=%h", got, e);
    end
  endtask

  initial begin
    m = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_load_hold();
    test_branch_over_load();
    test_struct_stall();
    test_imem_wait_redirect();
    test_wrap_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
